// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter plus APB-2 master that shares one slave among NREQ requesters.
// A HOLD phase with PSELx low lets the slave's one-cycle-lagging FSM execute exactly once.
module apb_master_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            req_ack,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       busy,
    output logic                       PSELx,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_WIDTH-1:0]      PADDR,
    output logic [DATA_WIDTH-1:0]      PWDATA,
    input  logic [DATA_WIDTH-1:0]      PRDATA
);

    localparam int unsigned IdxW = $clog2(NREQ);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StHold,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       winner_q, winner_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  grant_valid;
    logic [IdxW-1:0]       grant_idx;

    logic [ADDR_WIDTH-1:0] addr_arr  [NREQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NREQ];

    // Index 'off' positions after 'base', wrapping NREQ-1 -> 0.
    function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base,
                                               input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % NREQ;
        return sum[IdxW-1:0];
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IdxW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // ptr_q holds the first index to search, i.e. one past the last winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr_q;
        for (int unsigned off = 0; off < NREQ; off++) begin
            if (!grant_valid && req[rr_idx(ptr_q, off)]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_idx(ptr_q, off);
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            winner_q    <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d  = StSetup;
                    winner_d = grant_idx;
                    ptr_d    = rr_idx(grant_idx, 1);
                    pwrite_d = req_write[grant_idx];
                    paddr_d  = addr_arr[grant_idx];
                    pwdata_d = wdata_arr[grant_idx];
                end
            end
            StSetup:  state_d = StAccess;
            StAccess: state_d = StHold;
            StHold:   state_d = StDone;
            StDone: begin
                // Slave registered PRDATA at the end of HOLD; capture it now.
                state_d     = StIdle;
                rsp_valid_d = onehot(winner_q);
                rsp_rdata_d = pwrite_q ? '0 : PRDATA;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        req_ack = '0;
        busy    = (state_q != StIdle);
        unique case (state_q)
            StSetup: begin
                PSELx   = 1'b1;
                req_ack = onehot(winner_q);
            end
            StAccess: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
            end
            default: ;
        endcase
    end

    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    a_ack_onehot: assert property (@(posedge PCLK) disable iff (PRESET) $onehot0(req_ack));
    a_rsp_onehot: assert property (@(posedge PCLK) disable iff (PRESET) $onehot0(rsp_valid));
    a_ack_rsp_excl: assert property (@(posedge PCLK) disable iff (PRESET)
                                     !((|req_ack) && (|rsp_valid)));

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: lagging APB slave, transaction-schedule reference model,
// directed scenarios with literal expectations and a randomized phase.
module tb_apb_master_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 8;

    logic               PCLK = 1'b0;
    logic               PRESET = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    req_write = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_ack, rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               busy, PSELx, PENABLE, PWRITE;
    logic [AW-1:0]      PADDR;
    logic [DW-1:0]      PWDATA;
    logic [DW-1:0]      PRDATA = '0;

    int checks = 0;
    int failures = 0;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .PSELx(PSELx),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Slave with a one-cycle-lagging FSM; unwritten locations read as addr ^ 0x5A.
    logic [DW-1:0] slv_mem [256];
    bit            slv_vld [256];
    int            slv_state = 0;
    int            slv_writes = 0;
    always @(posedge PCLK) begin
        if (PRESET) begin
            slv_state <= 0;
        end else begin
            case (slv_state)
                0: if (PSELx) slv_state <= 1;
                1: slv_state <= PSELx ? 2 : 0;
                default: begin
                    if (PWRITE) begin
                        slv_mem[PADDR] <= PWDATA;
                        slv_vld[PADDR] <= 1'b1;
                        slv_writes     <= slv_writes + 1;
                    end else begin
                        PRDATA <= slv_vld[PADDR] ? slv_mem[PADDR] : (PADDR ^ 8'h5A);
                    end
                    slv_state <= PSELx ? 1 : 0;
                end
            endcase
        end
    end

    // Reference model: a transfer is a schedule of offsets from its grant edge.
    logic [DW-1:0] ref_mem [256];
    bit            ref_vld [256];
    bit            m_active = 1'b0;
    int            m_k = 0, m_ptr = 0, m_win = 0, model_writes = 0;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rd;
    logic          exp_psel, exp_pen, exp_pwrite, exp_busy;
    logic [AW-1:0] exp_paddr;
    logic [DW-1:0] exp_pwdata, exp_rdata;
    logic [NREQ-1:0] exp_ack, exp_rsp;
    bit            chk_en = 1'b0;

    always @(posedge PCLK) begin
        bit was;
        int c;
        was     = m_active;
        exp_rsp = '0;
        if (PRESET) begin
            chk_en     = 1'b1;
            m_active   = 1'b0;
            m_ptr      = 0;
            exp_pwrite = 1'b0;
            exp_paddr  = '0;
            exp_pwdata = '0;
        end else if (was) begin
            if (m_k == 3) begin
                if (m_wr) begin
                    ref_mem[m_addr] = m_wdata;
                    ref_vld[m_addr] = 1'b1;
                    model_writes++;
                end else begin
                    m_rd = ref_vld[m_addr] ? ref_mem[m_addr] : (m_addr ^ 8'h5A);
                end
            end
            if (m_k == 4) begin
                exp_rsp   = 4'(1 << m_win);
                exp_rdata = m_wr ? '0 : m_rd;
                m_active  = 1'b0;
            end
            m_k++;
        end else if (req != '0) begin
            for (int i = 0; i < NREQ; i++) begin
                c = (m_ptr + i) % NREQ;
                if (!m_active && req[c]) begin
                    m_active = 1'b1;
                    m_win    = c;
                end
            end
            m_ptr      = (m_win + 1) % NREQ;
            m_k        = 1;
            m_wr       = req_write[m_win];
            m_addr     = req_addr[m_win*AW +: AW];
            m_wdata    = req_wdata[m_win*DW +: DW];
            exp_pwrite = m_wr;
            exp_paddr  = m_addr;
            exp_pwdata = m_wdata;
        end
        exp_psel = m_active && (m_k <= 2);
        exp_pen  = m_active && (m_k == 2);
        exp_ack  = (m_active && m_k == 1) ? 4'(1 << m_win) : '0;
        exp_busy = m_active;
    end

    always @(negedge PCLK) begin
        if (chk_en) begin
            chk("m_psel", PSELx, exp_psel);
            chk("m_penable", PENABLE, exp_pen);
            chk("m_pwrite", PWRITE, exp_pwrite);
            chk("m_paddr", PADDR, exp_paddr);
            chk("m_pwdata", PWDATA, exp_pwdata);
            chk("m_req_ack", req_ack, exp_ack);
            chk("m_rsp_valid", rsp_valid, exp_rsp);
            chk("m_busy", busy, exp_busy);
            if (exp_rsp != '0) chk("m_rsp_rdata", rsp_rdata, exp_rdata);
        end
    end

    task automatic step();
        @(posedge PCLK);
        #2;
    endtask

    // One transfer with the phase-by-phase literal expectations.
    task automatic xfer(input int idx, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd);
        logic [NREQ-1:0] oh;
        int n;
        oh = 4'(1 << idx);
        req[idx]              = 1'b1;
        req_write[idx]        = wr;
        req_addr[idx*AW +: AW]  = a;
        req_wdata[idx*DW +: DW] = d;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (req_ack != oh && n < 20);
        chk("x_ack", req_ack, oh);
        chk("x_setup_psel", PSELx, 1);
        chk("x_setup_pen", PENABLE, 0);
        step();
        req[idx] = 1'b0;
        @(negedge PCLK);
        chk("x_access_psel", PSELx, 1);
        chk("x_access_pen", PENABLE, 1);
        @(negedge PCLK);
        chk("x_hold_psel", PSELx, 0);
        chk("x_hold_pen", PENABLE, 0);
        chk("x_hold_paddr", PADDR, a);
        chk("x_hold_pwrite", PWRITE, wr);
        if (wr) chk("x_hold_pwdata", PWDATA, d);
        @(negedge PCLK);
        chk("x_done_psel", PSELx, 0);
        chk("x_done_busy", busy, 1);
        chk("x_done_rsp", rsp_valid, 0);
        @(negedge PCLK);
        chk("x_rsp_valid", rsp_valid, oh);
        chk("x_rsp_rdata", rsp_rdata, exp_rd);
        chk("x_rsp_busy", busy, 0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1);
    end

    initial begin
        int order[$];
        int cyc_of[$];
        int cyc, w, n, w0;
        logic [NREQ-1:0] ack_s;

        PRESET = 1'b1;
        repeat (2) step();
        PRESET = 1'b0;

        // Write then read back through another requester.
        xfer(0, 1'b1, 8'h10, 8'hA5, 8'h00);
        xfer(1, 1'b0, 8'h10, 8'h00, 8'hA5);

        // Reset for two cycles while a read is in ACCESS.
        req[0] = 1'b1; req_write[0] = 1'b0; req_addr[0 +: AW] = 8'h30;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (req_ack != 4'b0001 && n < 20);
        chk("r_ack", req_ack, 4'b0001);
        step();
        req[0] = 1'b0;
        PRESET = 1'b1;
        step();
        @(negedge PCLK);
        chk("r_psel", PSELx, 0);
        chk("r_pen", PENABLE, 0);
        chk("r_pwrite", PWRITE, 0);
        chk("r_paddr", PADDR, 0);
        chk("r_pwdata", PWDATA, 0);
        chk("r_ack0", req_ack, 0);
        chk("r_rsp", rsp_valid, 0);
        chk("r_rdata", rsp_rdata, 0);
        chk("r_busy", busy, 0);
        step();
        PRESET = 1'b0;
        repeat (6) begin
            @(negedge PCLK);
            chk("r_no_rsp", rsp_valid, 0);
        end
        step();
        xfer(0, 1'b0, 8'h30, 8'h00, 8'h6A);

        // Top address, then write/read with one slave write per transfer.
        xfer(2, 1'b1, 8'hFF, 8'h3C, 8'h00);
        xfer(3, 1'b0, 8'hFF, 8'h00, 8'h3C);
        w0 = slv_writes;
        xfer(0, 1'b1, 8'h20, 8'h11, 8'h00);
        chk("one_write", slv_writes - w0, 1);
        xfer(0, 1'b0, 8'h20, 8'h00, 8'h11);
        chk("no_extra_write", slv_writes - w0, 1);

        // Priority after reset: all four requesting from reset release.
        PRESET = 1'b1;
        req = 4'hF; req_write = '0;
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = 8'(8'h40 + i);
        repeat (2) step();
        PRESET = 1'b0;
        cyc = 0;
        for (int k = 0; k < 40 && order.size() < 4; k++) begin
            @(negedge PCLK);
            cyc++;
            if (req_ack != '0) begin
                w = -1;
                for (int b = 0; b < NREQ; b++) if (req_ack[b]) w = b;
                order.push_back(w);
                cyc_of.push_back(cyc);
                ack_s = req_ack;
                step();
                req = req & ~ack_s;
            end
        end
        chk("prio_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk("prio_order", order[i], i);
        for (int i = 1; i < cyc_of.size(); i++) chk("prio_gap", cyc_of[i] - cyc_of[i-1], 5);
        req = '0;
        repeat (6) step();

        // Round-robin between two continuous requesters.
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        order.delete();
        req_addr[0 +: AW] = 8'h50; req_addr[2*AW +: AW] = 8'h52;
        req = 4'b0101;
        for (int k = 0; k < 40 && order.size() < 4; k++) begin
            @(negedge PCLK);
            if (req_ack != '0) begin
                w = -1;
                for (int b = 0; b < NREQ; b++) if (req_ack[b]) w = b;
                order.push_back(w);
            end
        end
        step();
        req = '0;
        chk("rr_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], (i % 2) * 2);
        repeat (6) step();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            PRESET = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                req[i]               = ($urandom_range(0, 2) == 0);
                req_write[i]         = $urandom_range(0, 1) == 1;
                req_addr[i*AW +: AW]  = ($urandom_range(0, 7) == 0) ? 8'hFF
                                                                    : 8'($urandom_range(0, 15));
                req_wdata[i*DW +: DW] = 8'($urandom_range(0, 255));
            end
            step();
        end
        PRESET = 1'b0;
        req = '0;
        repeat (8) step();
        chk("write_count", slv_writes, model_writes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
